// File: rtl/arm_pkg.sv
// Shared types and constants for the EXE/MEM pipeline boundary.
package arm_pkg;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
  } exe_mem_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready skid buffer with a generic payload.
// Handshake outputs come from the registered count only.
module skid_buf2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign in_ready  = (r_cnt != 2'(DEPTH));
  assign out_valid = (r_cnt != 2'd0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= in_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      // Simultaneous push and pop leaves the count unchanged.
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline register built on a two-entry skid buffer,
// plus the NZCV status register loaded on accepted S-bit beats.
module exe_mem_stage
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_res,
  input  logic [3:0]  alu_status,
  input  logic        s_en,
  input  logic [31:0] st_val,
  input  logic [3:0]  dest,
  input  logic        wb_en,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_alu_res,
  output logic [31:0] out_st_val,
  output logic [3:0]  out_dest,
  output logic        out_wb_en,
  output logic        out_mem_r_en,
  output logic        out_mem_w_en,
  output logic [3:0]  status,
  output logic        cin
);

  exe_mem_t   w_in;
  exe_mem_t   w_head;
  logic       w_push;
  logic [3:0] r_status;

  assign w_in = '{alu_res: alu_res, st_val: st_val, dest: dest,
                  wb_en: wb_en, mem_r_en: mem_r_en, mem_w_en: mem_w_en};

  skid_buf2 #(
    .WIDTH ($bits(exe_mem_t)),
    .DEPTH (DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_head)
  );

  assign w_push = in_valid && in_ready;

  // Flags follow acceptance, not MEM-side drain, so ID sees them one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status <= 4'd0;
    end else if (w_push && s_en) begin
      r_status <= alu_status;
    end
  end

  assign status       = r_status;
  assign cin          = r_status[NZCV_C];
  assign out_alu_res  = w_head.alu_res;
  assign out_st_val   = w_head.st_val;
  assign out_dest     = w_head.dest;
  assign out_wb_en    = w_head.wb_en;
  assign out_mem_r_en = w_head.mem_r_en;
  assign out_mem_w_en = w_head.mem_w_en;

endmodule
